// File: rtl/mem_responder_pkg.sv
// Shared widths and responder phase encoding.
// Used by the memory responder and its array.
package mem_responder_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array with a registered read.
// Reads are read-before-write; rdata is zero when not enabled.
module mem_array_sp
  import mem_responder_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the output register is reset; contents persist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
    else            rdata <= '0;
  end

endmodule

// File: rtl/mem_responder.sv
// Boot loader and run-time memory for the accumulator core.
// Holds the core in reset until the image is loaded.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] M,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          cpu_rst_n,
  output logic [15:0]   store_count,
  output logic          running
);

  state_t        state, state_nx;
  logic [AW-1:0] load_ptr;
  logic          wr_en_d;
  logic          accept, load_done, commit;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign accept    = (state == LOAD) && load_valid && load_ready;
  assign load_done = accept &&
                     (load_last || load_ptr == AW'(DEPTH-1));
  assign commit    = (state == RUN) && wr_en && !wr_en_d;

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (load_done) state_nx = RELEASE;
      RELEASE: state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      load_ptr    <= '0;
      load_ready  <= 1'b0;
      cpu_rst_n   <= 1'b0;
      running     <= 1'b0;
      wr_en_d     <= 1'b0;
      store_count <= '0;
    end else begin
      state      <= state_nx;
      wr_en_d    <= wr_en;
      load_ready <= (state_nx == LOAD);
      cpu_rst_n  <= (state_nx == RUN);
      running    <= (state_nx == RUN);
      if (accept) load_ptr <= load_ptr + 1'b1;
      if (commit && store_count != 16'hFFFF)
        store_count <= store_count + 1'b1;
    end
  end

  // Loader owns the port while loading; the core owns it in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_wdata = wr_data;
    unique case (1'b1)
      state == LOAD: begin
        mem_we    = accept;
        mem_addr  = load_ptr;
        mem_wdata = load_data;
      end
      state == RUN: mem_we = commit;
      default: ;
    endcase
  end

  mem_array_sp #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (state == RUN),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (M)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array model.
// Expected read data and store counts come from the model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] M;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        cpu_rst_n;
  logic [15:0] store_count;
  logic        running;

  mem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .M           (M),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_rst_n   (cpu_rst_n),
    .store_count (store_count),
    .running     (running)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] ref_mem [4096];
  bit          known [4096];
  int          ref_cnt = 0;
  logic        prev_wr = 1'b0;
  logic [15:0] img_q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    prev_wr = wr_en;
    #1;
  endtask

  task automatic do_reset;
    wr_en      = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_ready", load_ready, 0);
    check("rst_running", running, 0);
    check("rst_M", M, 0);
    check("rst_count", store_count, 0);
    ref_cnt = 0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("ready_after_rst", load_ready, 1);
  endtask

  // Streams img_q with random valid gaps; optionally checks release.
  task automatic load_image(input bit use_last, input bit finish,
                            input bit hold_we);
    int   i = 0;
    int   budget = img_q.size() * 4 + 40;
    logic rdy;
    while (i < img_q.size() && budget > 0) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = img_q[i];
      load_last  = use_last && (i == img_q.size() - 1);
      rdy = load_ready;
      check("cpu_held", cpu_rst_n, 0);
      tick;
      if (load_valid && rdy) begin
        ref_mem[i] = img_q[i];
        known[i]   = 1'b1;
        i++;
      end
      budget--;
    end
    check("load_beats", i, img_q.size());
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (finish) begin
      check("rel_ready", load_ready, 0);
      check("rel_cpu_rst_n", cpu_rst_n, 0);
      check("rel_running", running, 0);
      check("rel_M", M, 0);
      load_valid = 1'b1;
      load_data  = 16'hDEAD;
      wr_en      = hold_we;
      addr       = '0;
      wr_data    = 16'hFFFF;
      tick;
      check("run_cpu_rst_n", cpu_rst_n, 1);
      check("run_running", running, 1);
      check("run_ready", load_ready, 0);
    end
  endtask

  task automatic run_cycle(input logic [11:0] a, input logic w,
                           input logic [15:0] d);
    logic [15:0] e;
    bit          k;
    addr    = a;
    wr_en   = w;
    wr_data = d;
    e = ref_mem[a];
    k = known[a];
    if (w && !prev_wr) begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
      if (ref_cnt < 65535) ref_cnt++;
    end
    tick;
    if (k) check("rd", M, e);
    check("count", store_count, ref_cnt);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int j = 0; j < 4096; j++) known[j] = 1'b0;
    #2;
    do_reset;

    img_q = '{16'h2005, 16'h6000, 16'hA003};
    load_image(1'b1, 1'b1, 1'b1);
    run_cycle(12'h000, 1'b1, 16'hFFFF);
    check("held_entry_no_store", store_count, 0);
    check("t1_w0", M, 16'h2005);
    run_cycle(12'h001, 1'b0, 16'h0);
    check("t2_w1", M, 16'h6000);
    run_cycle(12'h002, 1'b0, 16'h0);
    check("t2_w2", M, 16'hA003);

    for (int j = 0; j < 3; j++) run_cycle(12'h010, 1'b1, 16'hBEEF);
    run_cycle(12'h010, 1'b0, 16'h0);
    check("t3_count", store_count, 1);
    run_cycle(12'h010, 1'b0, 16'h0);
    check("t3_rd", M, 16'hBEEF);

    run_cycle(12'h005, 1'b1, 16'h1111);
    run_cycle(12'h005, 1'b0, 16'h0);
    run_cycle(12'h005, 1'b1, 16'h2222);
    check("t4_old", M, 16'h1111);
    run_cycle(12'h005, 1'b1, 16'h2222);
    check("t4_new", M, 16'h2222);
    run_cycle(12'h005, 1'b0, 16'h0);

    for (int j = 0; j < 300; j++)
      run_cycle(12'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)),
                16'($urandom));

    do_reset;
    img_q.delete();
    for (int j = 0; j < 4096; j++) img_q.push_back(16'($urandom));
    load_image(1'b0, 1'b1, 1'b0);
    run_cycle(12'h000, 1'b0, 16'h0);
    check("t5_mem0", M, img_q[0]);
    run_cycle(12'hFFF, 1'b0, 16'h0);
    check("t5_last", M, img_q[4095]);
    for (int j = 0; j < 100; j++)
      run_cycle(12'($urandom), 1'($urandom_range(0, 1)),
                16'($urandom));

    do_reset;
    img_q = '{16'h1234, 16'h5678};
    load_image(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_async_cpu", cpu_rst_n, 0);
    check("t6_async_ready", load_ready, 0);
    do_reset;
    img_q = '{16'h7777};
    load_image(1'b1, 1'b1, 1'b0);
    run_cycle(12'h000, 1'b0, 16'h0);
    check("t6_mem0", M, 16'h7777);
    run_cycle(12'h001, 1'b0, 16'h0);
    check("t6_mem1", M, 16'h5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
